// File: rtl/logic_axi4_stream_packet_arbiter_pkg.sv
// Shared types for the packet-aware AXI4-Stream arbiter.
// Defines the two-state grant FSM encoding used by the top level.
package logic_axi4_stream_packet_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/logic_axi4_stream_if.sv
// AXI4-Stream bundle. The rx modport is the arbiter's view of an upstream
// source; the tx modport is its view of the downstream sink.
interface logic_axi4_stream_if #(
    parameter int TDATA_BYTES = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1,
    parameter int TID_WIDTH   = 1
);
    logic                       tvalid;
    logic                       tready;
    logic [TDATA_BYTES*8-1:0]   tdata;
    logic [TDATA_BYTES-1:0]     tkeep;
    logic [TDATA_BYTES-1:0]     tstrb;
    logic                       tlast;
    logic [TUSER_WIDTH-1:0]     tuser;
    logic [TDEST_WIDTH-1:0]     tdest;
    logic [TID_WIDTH-1:0]       tid;

    modport rx (input tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid, output tready);
    modport tx (output tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid, input tready);
endinterface

// File: rtl/logic_axi4_stream_arbiter_rr.sv
// Combinational round-robin pick: lowest requester at or above ptr_i,
// wrapping to input 0, found via a double-width masked priority encoder.
module logic_axi4_stream_arbiter_rr #(
    parameter int INPUTS      = 2,
    parameter int INDEX_WIDTH = 1
) (
    input  logic [INPUTS-1:0]      req_i,
    input  logic [INDEX_WIDTH-1:0] ptr_i,
    output logic [INPUTS-1:0]      grant_o,
    output logic [INDEX_WIDTH-1:0] index_o
);
    logic [2*INPUTS-1:0] req_dbl;
    logic [2*INPUTS-1:0] masked;
    logic                found;
    int                  pos;
    int                  sel;

    assign req_dbl = {req_i, req_i};

    // Upper copy is never masked, so requesters below ptr are reached by wrap.
    for (genvar gi = 0; gi < 2*INPUTS; gi++) begin : g_mask
        assign masked[gi] = req_dbl[gi] & (gi >= int'(ptr_i));
    end

    always_comb begin
        found = 1'b0;
        pos   = 0;
        for (int i = 2*INPUTS-1; i >= 0; i--) begin
            if (masked[i]) begin
                found = 1'b1;
                pos   = i;
            end
        end
        sel = (pos >= INPUTS) ? pos - INPUTS : pos;
        for (int i = 0; i < INPUTS; i++) begin
            grant_o[i] = found && (i == sel);
        end
        index_o = INDEX_WIDTH'(sel);
    end

endmodule

// File: rtl/logic_axi4_stream_packet_arbiter.sv
// Packet-aware round-robin arbiter sharing one AXI4-Stream output; grant is held
// from a packet's first offered beat through its end beat so packets never interleave.
module logic_axi4_stream_packet_arbiter
    import logic_axi4_stream_packet_arbiter_pkg::*;
#(
    parameter int INPUTS      = 2,
    parameter int TDATA_BYTES = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1,
    parameter int TID_WIDTH   = 1,
    parameter int USE_TLAST   = 1,
    parameter int USE_TKEEP   = 1,
    parameter int USE_TSTRB   = 1,
    parameter int MAX_BURST   = 16,
    parameter int INDEX_WIDTH = (INPUTS >= 2) ? $clog2(INPUTS) : 1
) (
    input  logic                   aclk,
    input  logic                   areset_n,
    logic_axi4_stream_if.rx        rx [INPUTS],
    logic_axi4_stream_if.tx        tx,
    output logic [INPUTS-1:0]      grant,
    output logic [INDEX_WIDTH-1:0] grant_index,
    output logic                   locked
);
    localparam int DW = TDATA_BYTES * 8;
    localparam int KW = TDATA_BYTES;
    localparam int CW = $clog2(MAX_BURST + 1);

    state_t                 state_q;
    logic [INDEX_WIDTH-1:0] ptr_q;
    logic [INDEX_WIDTH-1:0] ptr_d;
    logic [INDEX_WIDTH-1:0] gidx_q;
    logic [INPUTS-1:0]      gnt_q;
    logic [CW-1:0]          beat_cnt_q;

    logic [INPUTS-1:0]      req;
    logic [INPUTS-1:0]      rr_grant;
    logic [INDEX_WIDTH-1:0] rr_index;

    logic [DW-1:0]          rx_data [INPUTS];
    logic [KW-1:0]          rx_keep [INPUTS];
    logic [KW-1:0]          rx_strb [INPUTS];
    logic                   rx_last [INPUTS];
    logic [TUSER_WIDTH-1:0] rx_user [INPUTS];
    logic [TDEST_WIDTH-1:0] rx_dest [INPUTS];
    logic [TID_WIDTH-1:0]   rx_id   [INPUTS];

    logic                   tx_valid;
    logic [DW-1:0]          tx_data;
    logic [KW-1:0]          tx_keep;
    logic [KW-1:0]          tx_strb;
    logic                   tx_last;
    logic [TUSER_WIDTH-1:0] tx_user;
    logic [TDEST_WIDTH-1:0] tx_dest;
    logic [TID_WIDTH-1:0]   tx_id;
    logic                   fire;
    logic                   end_beat;

    for (genvar gi = 0; gi < INPUTS; gi++) begin : g_rx
        assign req[gi]         = rx[gi].tvalid;
        assign rx_data[gi]     = rx[gi].tdata;
        assign rx_keep[gi]     = rx[gi].tkeep;
        assign rx_strb[gi]     = rx[gi].tstrb;
        assign rx_last[gi]     = rx[gi].tlast;
        assign rx_user[gi]     = rx[gi].tuser;
        assign rx_dest[gi]     = rx[gi].tdest;
        assign rx_id[gi]       = rx[gi].tid;
        assign rx[gi].tready   = tx.tready & grant[gi];
    end

    logic_axi4_stream_arbiter_rr #(
        .INPUTS      (INPUTS),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_rr (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (rr_grant),
        .index_o (rr_index)
    );

    // Held low while reset is asserted so no source sees tready during reset.
    always_comb begin
        grant       = '0;
        grant_index = '0;
        if (areset_n) begin
            if (state_q == LOCKED) begin
                grant       = gnt_q;
                grant_index = gidx_q;
            end else begin
                grant       = rr_grant;
                grant_index = rr_index;
            end
        end
    end

    always_comb begin
        tx_data = '0;
        tx_keep = '0;
        tx_strb = '0;
        tx_last = 1'b0;
        tx_user = '0;
        tx_dest = '0;
        tx_id   = '0;
        for (int i = 0; i < INPUTS; i++) begin
            if (grant[i]) begin
                tx_data = tx_data | rx_data[i];
                tx_keep = tx_keep | rx_keep[i];
                tx_strb = tx_strb | rx_strb[i];
                tx_last = tx_last | rx_last[i];
                tx_user = tx_user | rx_user[i];
                tx_dest = tx_dest | rx_dest[i];
                tx_id   = tx_id   | rx_id[i];
            end
        end
    end

    assign tx_valid  = |(grant & req);
    assign tx.tvalid = tx_valid;
    assign tx.tdata  = tx_data;
    assign tx.tkeep  = (USE_TKEEP != 0) ? tx_keep : '1;
    assign tx.tstrb  = (USE_TSTRB != 0) ? tx_strb : '1;
    assign tx.tlast  = tx_last;
    assign tx.tuser  = tx_user;
    assign tx.tdest  = tx_dest;
    assign tx.tid    = tx_id;

    assign fire     = tx_valid & tx.tready;
    assign end_beat = fire & ((USE_TLAST != 0) ? tx_last
                                               : (beat_cnt_q == CW'(MAX_BURST - 1)));
    assign ptr_d    = (grant_index == INDEX_WIDTH'(INPUTS - 1)) ? '0 : grant_index + 1'b1;
    assign locked   = (state_q == LOCKED);

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            gidx_q     <= '0;
            gnt_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (end_beat) begin
                        ptr_q <= ptr_d;
                    end else if (tx_valid) begin
                        // Any offered beat not finishing a packet freezes the pick.
                        state_q    <= LOCKED;
                        gnt_q      <= grant;
                        gidx_q     <= grant_index;
                        beat_cnt_q <= fire ? CW'(1) : '0;
                    end
                end
                LOCKED: begin
                    if (end_beat) begin
                        state_q    <= IDLE;
                        ptr_q      <= ptr_d;
                        beat_cnt_q <= '0;
                    end else if (fire) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
